// File: rtl/cordic_host_if.sv
// rtl/cordic_host_if.sv - valid/ready front end for the pipelined CORDIC core
// Credits bound in-flight plus buffered requests to the response FIFO depth, so no core result can be lost.
module cordic_host_if #(
  parameter int IN_WIDTH   = 16,
  parameter int OUT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_mode,
  input  logic [IN_WIDTH-1:0]  req_x,
  input  logic [IN_WIDTH-1:0]  req_y,
  input  logic [IN_WIDTH-1:0]  req_z,
  output logic                 core_en,
  output logic [1:0]           core_mode,
  output logic [IN_WIDTH-1:0]  core_x,
  output logic [IN_WIDTH-1:0]  core_y,
  output logic [IN_WIDTH-1:0]  core_z,
  input  logic                 core_ready,
  input  logic [OUT_WIDTH-1:0] core_r,
  input  logic [OUT_WIDTH-1:0] core_a,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [OUT_WIDTH-1:0] rsp_r,
  output logic [OUT_WIDTH-1:0] rsp_a,
  output logic [1:0]           rsp_mode,
  output logic                 rsp_err,
  output logic                 err_proto,
  output logic                 err_timeout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = 2 * OUT_WIDTH + 3;
  localparam int WW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] used;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] rsp_count;
  logic          accept;
  logic          ret_ok;
  logic          rsp_push;
  logic          rsp_pop;
  logic          rsp_full;
  logic          req_illegal;

  assign req_ready   = (used < CW'(FIFO_DEPTH));
  assign accept      = req_valid & req_ready;
  assign req_illegal = (req_mode == 2'd0) || (req_mode == 2'd3);
  // A core result is only meaningful while something is outstanding; otherwise it is dropped.
  assign ret_ok      = core_ready & (outstanding != '0);
  assign rsp_push    = ret_ok;
  assign rsp_valid   = (rsp_count != '0);
  assign rsp_pop     = rsp_valid & rsp_ready;
  assign rsp_full    = (rsp_count == CW'(FIFO_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      used <= '0;
    end else if (accept && !rsp_pop) begin
      used <= used + CW'(1);
    end else if (!accept && rsp_pop) begin
      used <= used - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else if (accept && !ret_ok) begin
      outstanding <= outstanding + CW'(1);
    end else if (!accept && ret_ok) begin
      outstanding <= outstanding - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_en   <= 1'b0;
      core_mode <= 2'd0;
      core_x    <= '0;
      core_y    <= '0;
      core_z    <= '0;
    end else begin
      core_en <= accept;
      if (accept) begin
        core_mode <= req_mode;
        core_x    <= req_x;
        core_y    <= req_y;
        core_z    <= req_z;
      end
    end
  end

  // Tag FIFO: occupancy always equals outstanding, so it needs no count of its own.
  logic [2:0]    tag_mem [FIFO_DEPTH];
  logic [AW-1:0] tag_wr;
  logic [AW-1:0] tag_rd;

  always_ff @(posedge clk) begin
    if (accept) begin
      tag_mem[tag_wr] <= {req_mode, req_illegal};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_wr <= '0;
      tag_rd <= '0;
    end else begin
      if (accept) begin
        tag_wr <= tag_wr + AW'(1);
      end
      if (ret_ok) begin
        tag_rd <= tag_rd + AW'(1);
      end
    end
  end

  logic [RW-1:0] rsp_mem [FIFO_DEPTH];
  logic [AW-1:0] rsp_wr;
  logic [AW-1:0] rsp_rd;

  always_ff @(posedge clk) begin
    if (rsp_push) begin
      rsp_mem[rsp_wr] <= {tag_mem[tag_rd], core_r, core_a};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_wr    <= '0;
      rsp_rd    <= '0;
      rsp_count <= '0;
    end else begin
      if (rsp_push) begin
        rsp_wr <= rsp_wr + AW'(1);
      end
      if (rsp_pop) begin
        rsp_rd <= rsp_rd + AW'(1);
      end
      if (rsp_push && !rsp_pop) begin
        rsp_count <= rsp_count + CW'(1);
      end else if (!rsp_push && rsp_pop) begin
        rsp_count <= rsp_count - CW'(1);
      end
    end
  end

  // Show-ahead read, forced to zero when empty so stale entries never reach the outputs.
  assign {rsp_mode, rsp_err, rsp_r, rsp_a} = rsp_valid ? rsp_mem[rsp_rd] : '0;

  logic [WW-1:0] wd_cnt;
  logic          wd_run;
  logic          wd_hit;

  assign wd_run = (outstanding != '0) && !core_ready;
  assign wd_hit = wd_run && (wd_cnt == WW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
      err_proto   <= 1'b0;
    end else begin
      if (!wd_run) begin
        wd_cnt <= '0;
      end else if (wd_cnt != WW'(TIMEOUT)) begin
        wd_cnt <= wd_cnt + WW'(1);
      end
      if (wd_hit) begin
        err_timeout <= 1'b1;
      end
      if (core_ready && (outstanding == '0) && !accept) begin
        err_proto <= 1'b1;
      end
    end
  end

  rsp_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(rsp_push && rsp_full && !rsp_pop));

endmodule

// File: tb/tb_cordic_host_if.sv
// tb/tb_cordic_host_if.sv - scoreboard bench for cordic_host_if driving a behavioural core stand-in
module tb_cordic_host_if;

  localparam int LAT = 4;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_mode;
  logic [15:0] req_x;
  logic [15:0] req_y;
  logic [15:0] req_z;
  logic        core_en;
  logic [1:0]  core_mode;
  logic [15:0] core_x;
  logic [15:0] core_y;
  logic [15:0] core_z;
  logic        core_ready;
  logic [15:0] core_r;
  logic [15:0] core_a;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_r;
  logic [15:0] rsp_a;
  logic [1:0]  rsp_mode;
  logic        rsp_err;
  logic        err_proto;
  logic        err_timeout;

  logic        core_mute;
  logic        force_rdy;

  int          n_tests;
  int          n_fail;
  int          acc_cnt;
  int          rsp_cnt;
  int          stall_cnt;
  logic [15:0] last_r;
  logic [34:0] sb[$];

  cordic_host_if dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_mode    (req_mode),
    .req_x       (req_x),
    .req_y       (req_y),
    .req_z       (req_z),
    .core_en     (core_en),
    .core_mode   (core_mode),
    .core_x      (core_x),
    .core_y      (core_y),
    .core_z      (core_z),
    .core_ready  (core_ready),
    .core_r      (core_r),
    .core_a      (core_a),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_r       (rsp_r),
    .rsp_a       (rsp_a),
    .rsp_mode    (rsp_mode),
    .rsp_err     (rsp_err),
    .err_proto   (err_proto),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] isqrt(input logic [63:0] v);
    logic [31:0] r;
    logic [31:0] t;
    r = '0;
    for (int b = 31; b >= 0; b--) begin
      t = r | (32'd1 << b);
      if ({32'd0, t} * {32'd0, t} <= v) r = t;
    end
    return r;
  endfunction

  // Stand-in core arithmetic: vector gives magnitude, rotate a simple affine mix, illegal gives zero.
  function automatic logic [31:0] model(input logic [1:0] m, input logic [15:0] x,
                                        input logic [15:0] y, input logic [15:0] z);
    logic [31:0] mag;
    logic [63:0] sq;
    logic [15:0] rr;
    logic [15:0] aa;
    rr = '0;
    aa = '0;
    if (m == 2'd1) begin
      sq  = {48'd0, x} * {48'd0, x} + {48'd0, y} * {48'd0, y};
      mag = isqrt(sq);
      rr  = mag[15:0];
      aa  = x ^ y;
    end else if (m == 2'd2) begin
      rr = x + z;
      aa = y - z;
    end
    return {rr, aa};
  endfunction

  logic [LAT-1:0] pv;
  logic [15:0]    pr [LAT];
  logic [15:0]    pa [LAT];
  logic [31:0]    cres;

  assign cres = model(core_mode, core_x, core_y, core_z);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
    end else begin
      pv    <= {pv[LAT-2:0], core_en};
      pr[0] <= cres[31:16];
      pa[0] <= cres[15:0];
      for (int i = 1; i < LAT; i++) begin
        pr[i] <= pr[i-1];
        pa[i] <= pa[i-1];
      end
    end
  end

  assign core_ready = (pv[LAT-1] & ~core_mute) | force_rdy;
  assign core_r     = pr[LAT-1];
  assign core_a     = pa[LAT-1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] m, input logic [15:0] x, input logic [15:0] y,
                      input logic [15:0] z);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_mode  = m;
    req_x     = x;
    req_y     = y;
    req_z     = z;
    while (!req_ready && n < 200) begin
      tick();
      n++;
    end
    if (!req_ready) check("send_timeout", 64'd0, 64'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || rsp_valid) && n < budget) begin
      tick();
      n++;
    end
    check("drain", {63'd0, (sb.size() == 0 && !rsp_valid)}, 64'd1);
  endtask

  // Monitor: sampled on the falling edge, predicts at accept and compares at pop.
  initial begin
    logic        prev_acc;
    logic [15:0] prev_x;
    logic        prev_hold;
    logic [34:0] prev_rsp;
    logic [34:0] e;
    logic [31:0] m;
    prev_acc  = 1'b0;
    prev_x    = '0;
    prev_hold = 1'b0;
    prev_rsp  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        prev_acc  = 1'b0;
        prev_hold = 1'b0;
      end else begin
        check("core_en", {63'd0, core_en}, {63'd0, prev_acc});
        if (prev_acc) check("core_x", {48'd0, core_x}, {48'd0, prev_x});
        if (prev_hold) check("rsp_hold", {29'd0, rsp_mode, rsp_err, rsp_r, rsp_a}, {29'd0, prev_rsp});
        prev_hold = rsp_valid && !rsp_ready;
        prev_rsp  = {rsp_mode, rsp_err, rsp_r, rsp_a};
        prev_acc  = req_valid & req_ready;
        prev_x    = req_x;
        if (req_valid && !req_ready) stall_cnt++;
        if (prev_acc) begin
          m = model(req_mode, req_x, req_y, req_z);
          sb.push_back({req_mode, (req_mode == 2'd0 || req_mode == 2'd3), m});
          acc_cnt++;
        end
        if (rsp_valid && rsp_ready) begin
          if (sb.size() == 0) begin
            check("rsp_unexpected", 64'd1, 64'd0);
          end else begin
            e = sb.pop_front();
            check("rsp", {29'd0, rsp_mode, rsp_err, rsp_r, rsp_a}, {29'd0, e});
          end
          last_r = rsp_r;
          rsp_cnt++;
        end
      end
    end
  end

  initial begin
    int a0;
    int r0;
    n_tests   = 0;
    n_fail    = 0;
    acc_cnt   = 0;
    rsp_cnt   = 0;
    stall_cnt = 0;
    last_r    = '0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_mode  = 2'd0;
    req_x     = '0;
    req_y     = '0;
    req_z     = '0;
    rsp_ready = 1'b1;
    core_mute = 1'b0;
    force_rdy = 1'b0;
    repeat (3) tick();
    check("rst_core_en", {63'd0, core_en}, 64'd0);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_rsp_r", {48'd0, rsp_r}, 64'd0);
    check("rst_err_proto", {63'd0, err_proto}, 64'd0);
    check("rst_err_timeout", {63'd0, err_timeout}, 64'd0);
    rst_n = 1'b1;
    tick();
    check("idle_req_ready", {63'd0, req_ready}, 64'd1);

    send(2'd1, 16'd3000, 16'd4000, 16'd0);
    drain(100);
    check("vec_r_5000", {63'd0, (last_r >= 16'd4998 && last_r <= 16'd5002)}, 64'd1);

    stall_cnt = 0;
    a0 = acc_cnt;
    r0 = rsp_cnt;
    for (int i = 0; i < 20; i++) begin
      send(2'd2, 16'($urandom_range(0, 30000)), 16'($urandom_range(0, 30000)),
           16'($urandom_range(0, 30000)));
    end
    drain(200);
    check("stream_stalls", 64'(stall_cnt), 64'd0);
    check("stream_accepts", 64'(acc_cnt - a0), 64'd20);
    check("stream_rsps", 64'(rsp_cnt - r0), 64'd20);

    rsp_ready = 1'b0;
    a0 = acc_cnt;
    req_valid = 1'b1;
    req_mode  = 2'd2;
    req_x     = 16'd100;
    req_y     = 16'd200;
    req_z     = 16'd7;
    repeat (20) tick();
    check("bp_accepts", 64'(acc_cnt - a0), 64'd8);
    check("bp_req_ready_low", {63'd0, req_ready}, 64'd0);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    check("bp_ready_before_pop", {63'd0, req_ready}, 64'd0);
    tick();
    check("bp_ready_after_pop", {63'd0, req_ready}, 64'd1);
    drain(100);

    send(2'd3, 16'd1234, 16'd555, 16'd99);
    send(2'd0, 16'd42, 16'd43, 16'd44);
    send(2'd1, 16'($urandom_range(0, 12000)), 16'($urandom_range(0, 12000)), 16'd0);
    drain(100);
    check("no_err_proto", {63'd0, err_proto}, 64'd0);
    check("no_err_timeout", {63'd0, err_timeout}, 64'd0);

    force_rdy = 1'b1;
    tick();
    force_rdy = 1'b0;
    check("proto_set", {63'd0, err_proto}, 64'd1);
    check("proto_no_rsp", {63'd0, rsp_valid}, 64'd0);

    core_mute = 1'b1;
    send(2'd1, 16'd10, 16'd20, 16'd0);
    repeat (30) tick();
    check("wd_early", {63'd0, err_timeout}, 64'd0);
    repeat (40) tick();
    check("wd_set", {63'd0, err_timeout}, 64'd1);
    check("proto_sticky", {63'd0, err_proto}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_clr_proto", {63'd0, err_proto}, 64'd0);
    check("rst_clr_timeout", {63'd0, err_timeout}, 64'd0);
    tick();
    core_mute = 1'b0;
    rst_n = 1'b1;
    tick();

    rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send(2'd2, 16'(i * 11), 16'(i * 13), 16'(i * 17));
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_core_en", {63'd0, core_en}, 64'd0);
    check("mid_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("mid_rst_rsp_r", {48'd0, rsp_r}, 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    r0 = rsp_cnt;
    tick();
    check("mid_rst_req_ready", {63'd0, req_ready}, 64'd1);
    repeat (20) tick();
    check("no_stale_rsps", 64'(rsp_cnt - r0), 64'd0);
    check("no_stale_proto", {63'd0, err_proto}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_host_if.md
Name: cordic_host_if

Overview:
- Request-side front end for the pipelined CORDIC core. It drives the core's en_in/mode/x/y/z inputs and collects its ready_out/r/a results.
- The core cannot stall, so this block adds valid/ready flow control on both the request and response sides.
- A credit counter sized to an internal response FIFO guarantees no core result is ever dropped. A mode tag FIFO labels each response.
- Sits between the system datapath and cordic_top, one instance per core.

Parameters:
IN_WIDTH, 16, width of x/y/z request operands (matches core input width)
OUT_WIDTH, 16, width of r/a results (matches core output width)
FIFO_DEPTH, 8, response FIFO and tag FIFO depth; maximum requests in flight plus buffered (power of 2, >=2)
TIMEOUT, 64, cycles without core_ready while requests are outstanding before err_timeout sets

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid&req_ready
req_mode  in  2  1=vector (r,angle), 2=rotate, 0/3 illegal
req_x  in  IN_WIDTH  x operand
req_y  in  IN_WIDTH  y operand
req_z  in  IN_WIDTH  z angle operand
core_en  out  1  to core en_in
core_mode  out  2  to core mode_in
core_x  out  IN_WIDTH  to core x_in
core_y  out  IN_WIDTH  to core y_in
core_z  out  IN_WIDTH  to core z_in
core_ready  in  1  from core ready_out
core_r  in  OUT_WIDTH  from core r_out
core_a  in  OUT_WIDTH  from core a_out
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when rsp_valid&rsp_ready
rsp_r  out  OUT_WIDTH  r result
rsp_a  out  OUT_WIDTH  a result
rsp_mode  out  2  mode of the originating request
rsp_err  out  1  originating request had illegal mode (0/3)
err_proto  out  1  sticky: core_ready received with zero outstanding
err_timeout  out  1  sticky: watchdog expired

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Reset values: all outputs 0; all counters and FIFOs cleared. An asserted reset mid-operation discards all in-flight and buffered data; the core shares rst_n.
- Credit counter `used`:
  - Range 0..FIFO_DEPTH.
  - +1 on request accept, -1 on response pop; both in the same cycle leaves it unchanged.
  - req_ready = (used < FIFO_DEPTH). It is a combinational function of registers and never depends on req_valid.
- Issue path:
  - On accept, core_en/core_mode/core_x/core_y/core_z are registered and presented for exactly one cycle, in the cycle after accept.
  - core_en is 0 otherwise; core_x/y/z/mode hold their last values.
  - Back-to-back accepts give back-to-back core_en pulses.
- Illegal modes (0/3) are still issued; the core returns zeros. Their tag carries err=1.
- Tag FIFO:
  - Width 3: mode plus err.
  - Pushed on accept, popped on core_ready.
  - Its output pairs with core_r/core_a into the response FIFO entry.
- Outstanding counter: +1 on accept, -1 on core_ready.
- Protocol error: core_ready when outstanding==0 (and no accept in the same cycle) sets err_proto. The result is dropped; no push, no counter change.
- Response FIFO:
  - Width 2*OUT_WIDTH+3, show-ahead.
  - An entry pushed at edge N is visible on rsp_* from cycle N+1 with rsp_valid=1.
  - Push and pop in the same cycle are both allowed, including when full.
  - Overflow is impossible by construction; an assertion must flag a push when full.
  - rsp_* hold stable while rsp_valid&!rsp_ready.
- Ordering: responses are strictly in request order.
- Watchdog:
  - Counter increments each cycle while outstanding>0 and core_ready=0.
  - Clears on core_ready or when outstanding==0.
  - Reaching TIMEOUT sets err_timeout.
  - Only rst_n clears the sticky error bits.
- Latency: independent of core depth. The response appears one cycle after core_ready.

Test Plan:
- Single vector request: mode=1, x=3000, y=4000. Expect one core_en pulse the cycle after accept, then rsp_valid with rsp_mode=1, rsp_err=0, rsp_r≈5000 (±2 LSB).
- Streaming: 20 back-to-back mode=2 requests with rsp_ready=1, FIFO_DEPTH=8. Expect req_ready to stay 1, 20 contiguous core_en pulses, and 20 responses in order with matching modes.
- Backpressure: rsp_ready=0, req_valid=1 continuously. Expect exactly 8 accepts, then req_ready=0. After releasing rsp_ready, all 8 responses drain and req_ready returns in the cycle after the first pop.
- Illegal mode: req_mode=3. Expect core_en issued and a response with rsp_err=1, rsp_r=0, rsp_a=0, rsp_mode=3.
- Error flags:
  - Force core_ready with nothing outstanding → err_proto=1, no rsp_valid.
  - Block core_ready for 64 cycles after a request → err_timeout=1.
  - Assert rst_n=0 → both flags clear.
- Reset mid-stream: assert rst_n with 5 outstanding and 3 buffered. Expect immediate zero outputs and req_ready=1 after release, with no stale responses.
